// File: rtl/rfid_pkg.sv
// Shared types and constants for the RFID UID matcher: FSM encoding,
// reserved UID patterns and the default repeat-suppression window.
package rfid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_REPORT,
    ST_HOLDOFF
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_MATCH,
    RES_UNKNOWN,
    RES_LEARNED
  } result_t;

  localparam int UID_W_DEFAULT = 32;

  // Reader returns all-zeros for "no card" and all-ones on a bus fault.
  localparam logic [UID_W_DEFAULT-1:0] UID_NONE  = '0;
  localparam logic [UID_W_DEFAULT-1:0] UID_FAULT = '1;

  localparam int HOLDOFF_DEFAULT = 50_000_000;

endpackage

// File: rtl/rfid_uid_matcher.sv
// Classifies RC522 UIDs against a small register table of registered cards,
// with learn/clear commands and a holdoff that suppresses repeated reads.
module rfid_uid_matcher
  import rfid_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int UID_W          = UID_W_DEFAULT,
  parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [UID_W-1:0]             uid,
  input  logic                         uid_valid,
  input  logic                         learn_req,
  input  logic [$clog2(NUM_SLOTS)-1:0] learn_slot,
  input  logic                         clear_all,
  output logic                         match,
  output logic [$clog2(NUM_SLOTS)-1:0] match_slot,
  output logic                         unknown,
  output logic                         learned,
  output logic                         learn_armed,
  output logic [NUM_SLOTS-1:0]         slot_valid,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [UID_W-1:0] NONE_PAT  = {UID_W{UID_NONE[0]}};
  localparam logic [UID_W-1:0] FAULT_PAT = {UID_W{UID_FAULT[0]}};
  localparam logic [IW-1:0]    LAST_IDX  = IW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0]    HOLD_LOAD = CW'(HOLDOFF_CYCLES);

  state_t            state, state_n;
  result_t           result;
  logic [UID_W-1:0]  uid_table [NUM_SLOTS];
  logic [UID_W-1:0]  cur_uid, last_uid;
  logic [IW-1:0]     idx, target, learn_tgt;
  logic              learn_mode;
  logic [CW-1:0]     hold_cnt;

  logic uid_ok, accept, refresh, slot_hit, last_slot, to_report, learn_done;

  assign uid_ok     = uid_valid && (uid != NONE_PAT) && (uid != FAULT_PAT);
  assign accept     = uid_ok && !clear_all &&
                      ((state == ST_IDLE) || ((state == ST_HOLDOFF) && (uid != last_uid)));
  assign refresh    = uid_ok && !clear_all && (state == ST_HOLDOFF) && (uid == last_uid);
  assign slot_hit   = slot_valid[idx] && (uid_table[idx] == cur_uid);
  assign last_slot  = (idx == LAST_IDX);
  // Learn scans never exit early so every stale copy of the UID gets dropped.
  assign to_report  = (state == ST_COMPARE) && !clear_all &&
                      (last_slot || (!learn_mode && slot_hit));
  assign learn_done = to_report && learn_mode;
  assign busy       = (state == ST_COMPARE) || (state == ST_REPORT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    match   = 1'b0;
    unknown = 1'b0;
    learned = 1'b0;
    if (clear_all) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (accept) state_n = ST_COMPARE;
        ST_COMPARE: if (to_report) state_n = ST_REPORT;
        ST_REPORT: begin
          state_n = ST_HOLDOFF;
          match   = (result == RES_MATCH);
          unknown = (result == RES_UNKNOWN);
          learned = (result == RES_LEARNED);
        end
        ST_HOLDOFF: begin
          if (accept)                            state_n = ST_COMPARE;
          else if (!refresh && hold_cnt == '0)   state_n = ST_IDLE;
        end
        default:    state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) uid_table[i] <= '0;
      slot_valid  <= '0;
      cur_uid     <= '0;
      last_uid    <= '0;
      idx         <= '0;
      target      <= '0;
      learn_tgt   <= '0;
      learn_mode  <= 1'b0;
      learn_armed <= 1'b0;
      hold_cnt    <= '0;
      match_slot  <= '0;
      result      <= RES_NONE;
    end else begin
      if (accept) begin
        cur_uid    <= uid;
        last_uid   <= uid;
        learn_mode <= learn_armed;
        learn_tgt  <= target;
        idx        <= '0;
      end

      if (state == ST_COMPARE && !clear_all) begin
        idx <= idx + IW'(1);
        if (learn_mode) begin
          if (slot_hit && idx != learn_tgt) slot_valid[idx] <= 1'b0;
          if (last_slot) begin
            uid_table[learn_tgt]  <= cur_uid;
            slot_valid[learn_tgt] <= 1'b1;
            result                <= RES_LEARNED;
          end
        end else if (slot_hit) begin
          result     <= RES_MATCH;
          match_slot <= idx;
        end else if (last_slot) begin
          result <= RES_UNKNOWN;
        end
      end

      if (clear_all) slot_valid <= '0;

      // A fresh learn_req wins over the completion of an earlier learn.
      if (clear_all) begin
        learn_armed <= 1'b0;
      end else if (learn_req) begin
        learn_armed <= 1'b1;
        target      <= learn_slot;
      end else if (learn_done) begin
        learn_armed <= 1'b0;
      end

      if (clear_all)                              hold_cnt <= '0;
      else if (state == ST_REPORT || refresh)     hold_cnt <= HOLD_LOAD;
      else if (state == ST_HOLDOFF && hold_cnt != '0) hold_cnt <= hold_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_rfid_uid_matcher.sv
// Directed bench for rfid_uid_matcher: a vector table of learn/read
// transactions plus hand sequences for holdoff, filtering, clear and reset.
module tb_rfid_uid_matcher;

  localparam int NUM_SLOTS = 4;
  localparam int UID_W     = 32;
  localparam int HOLDOFF   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] uid = '0;
  logic        uid_valid = 1'b0;
  logic        learn_req = 1'b0;
  logic [1:0]  learn_slot = '0;
  logic        clear_all = 1'b0;
  logic        match, unknown, learned, learn_armed, busy;
  logic [1:0]  match_slot;
  logic [3:0]  slot_valid;

  int tests_run = 0;
  int failures  = 0;
  int n_match, n_unknown, n_learned, n_busy, first_edge, got_kind;
  logic [1:0] seen_slot;

  rfid_uid_matcher #(
    .NUM_SLOTS(NUM_SLOTS), .UID_W(UID_W), .HOLDOFF_CYCLES(HOLDOFF)
  ) dut (
    .clk(clk), .rst(rst), .uid(uid), .uid_valid(uid_valid),
    .learn_req(learn_req), .learn_slot(learn_slot), .clear_all(clear_all),
    .match(match), .match_slot(match_slot), .unknown(unknown),
    .learned(learned), .learn_armed(learn_armed), .slot_valid(slot_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          learn;
    logic [1:0]  slot;
    logic [31:0] uid;
    int          kind;
    int          at_edge;
    logic [1:0]  exp_slot;
    logic [3:0]  exp_valid;
  } vec_t;

  vec_t vecs[9];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] u);
    uid       = u;
    uid_valid = 1'b1;
    tick();
    uid_valid = 1'b0;
  endtask

  task automatic pulse_learn(input logic [1:0] s);
    learn_req  = 1'b1;
    learn_slot = s;
    tick();
    learn_req  = 1'b0;
  endtask

  // Edge j counts clock edges after the accept edge; a pulse seen at j=k
  // is high between E(k) and E(k+1).
  task automatic observe(input int cycles);
    n_match = 0; n_unknown = 0; n_learned = 0; n_busy = 0; first_edge = -1;
    seen_slot = '0;
    for (int j = 1; j <= cycles; j++) begin
      tick();
      if (busy) n_busy++;
      if (match) begin
        n_match++;
        seen_slot = match_slot;
        if (first_edge < 0) first_edge = j;
      end
      if (unknown) begin
        n_unknown++;
        if (first_edge < 0) first_edge = j;
      end
      if (learned) begin
        n_learned++;
        if (first_edge < 0) first_edge = j;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 2'd2, 32'hA1B2C3D4, 3, 4, 2'd0, 4'b0100};
    vecs[1] = '{1'b0, 2'd0, 32'hA1B2C3D4, 1, 3, 2'd2, 4'b0100};
    vecs[2] = '{1'b0, 2'd0, 32'h55667788, 2, 4, 2'd0, 4'b0100};
    vecs[3] = '{1'b1, 2'd0, 32'h11223344, 3, 4, 2'd0, 4'b0101};
    vecs[4] = '{1'b1, 2'd1, 32'h11223344, 3, 4, 2'd0, 4'b0110};
    vecs[5] = '{1'b0, 2'd0, 32'h11223344, 1, 2, 2'd1, 4'b0110};
    vecs[6] = '{1'b1, 2'd3, 32'hCAFEBABE, 3, 4, 2'd0, 4'b1110};
    vecs[7] = '{1'b0, 2'd0, 32'hCAFEBABE, 1, 4, 2'd3, 4'b1110};
    vecs[8] = '{1'b0, 2'd0, 32'hA1B2C3D4, 1, 3, 2'd2, 4'b1110};

    #2;
    check_output("reset outputs",
                 {match, unknown, learned, learn_armed, busy, match_slot, slot_valid}, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      repeat (30) tick();
      if (vecs[i].learn) pulse_learn(vecs[i].slot);
      apply_stimulus(vecs[i].uid);
      observe(8);
      got_kind = (n_match != 0) ? 1 : (n_unknown != 0) ? 2 : (n_learned != 0) ? 3 : 0;
      check_output($sformatf("vec%0d kind", i), got_kind, vecs[i].kind);
      check_output($sformatf("vec%0d pulses", i), n_match + n_unknown + n_learned, 1);
      check_output($sformatf("vec%0d latency", i), first_edge, vecs[i].at_edge);
      if (vecs[i].kind == 1)
        check_output($sformatf("vec%0d match_slot", i), seen_slot, vecs[i].exp_slot);
      check_output($sformatf("vec%0d slot_valid", i), slot_valid, vecs[i].exp_valid);
      check_output($sformatf("vec%0d learn_armed", i), learn_armed, 0);
    end

    // Same card left on the antenna: holdoff keeps reloading, one match only.
    repeat (30) tick();
    n_match = 0; n_unknown = 0; n_learned = 0; seen_slot = '0;
    for (int c = 0; c < 100; c++) begin
      uid       = 32'hA1B2C3D4;
      uid_valid = (c % 5 == 0);
      tick();
      if (match) begin
        n_match++;
        seen_slot = match_slot;
      end
      if (unknown) n_unknown++;
      if (learned) n_learned++;
    end
    uid_valid = 1'b0;
    check_output("repeat matches", n_match, 1);
    check_output("repeat other pulses", n_unknown + n_learned, 0);
    check_output("repeat match_slot", seen_slot, 2);
    apply_stimulus(32'h5A5A5A5A);
    observe(8);
    check_output("holdoff new uid unknown", n_unknown, 1);
    check_output("holdoff new uid latency", first_edge, 4);
    check_output("holdoff new uid no match", n_match + n_learned, 0);

    // Reserved UIDs are ignored outright.
    repeat (30) tick();
    apply_stimulus(32'h00000000);
    observe(6);
    check_output("uid zero pulses", n_match + n_unknown + n_learned, 0);
    check_output("uid zero busy", n_busy, 0);
    apply_stimulus(32'hFFFFFFFF);
    observe(6);
    check_output("uid ones pulses", n_match + n_unknown + n_learned, 0);
    check_output("uid ones busy", n_busy, 0);

    // A second read arriving mid-compare is dropped, not queued.
    repeat (30) tick();
    apply_stimulus(32'hA1B2C3D4);
    tick();
    check_output("busy during compare", busy, 1);
    uid       = 32'hCAFEBABE;
    uid_valid = 1'b1;
    tick();
    uid_valid = 1'b0;
    observe(10);
    check_output("busy drop matches", n_match, 1);
    check_output("busy drop latency", first_edge, 1);
    check_output("busy drop slot", seen_slot, 2);
    check_output("busy drop other pulses", n_unknown + n_learned, 0);
    check_output("busy drop busy cycles", n_busy, 1);

    // clear_all mid-compare aborts silently and wipes the table flags.
    repeat (30) tick();
    pulse_learn(2'd0);
    check_output("learn armed", learn_armed, 1);
    apply_stimulus(32'hCAFEBABE);
    tick();
    check_output("busy before clear", busy, 1);
    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    check_output("clear busy", busy, 0);
    check_output("clear slot_valid", slot_valid, 4'b0000);
    check_output("clear learn_armed", learn_armed, 0);
    observe(6);
    check_output("clear no pulses", n_match + n_unknown + n_learned, 0);
    learn_req  = 1'b1;
    learn_slot = 2'd3;
    clear_all  = 1'b1;
    tick();
    learn_req  = 1'b0;
    clear_all  = 1'b0;
    check_output("clear beats learn", learn_armed, 0);

    // Async reset while sitting in holdoff.
    pulse_learn(2'd1);
    apply_stimulus(32'h0BADF00D);
    observe(6);
    check_output("relearn learned", n_learned, 1);
    check_output("relearn latency", first_edge, 4);
    check_output("relearn slot_valid", slot_valid, 4'b0010);
    pulse_learn(2'd2);
    check_output("pre-reset learn_armed", learn_armed, 1);
    #3;
    rst = 1'b1;
    #1;
    check_output("async reset outputs",
                 {match, unknown, learned, learn_armed, busy, match_slot, slot_valid}, '0);
    #2;
    rst = 1'b0;
    tick();
    apply_stimulus(32'h0BADF00D);
    observe(8);
    check_output("post-reset unknown", n_unknown, 1);
    check_output("post-reset latency", first_edge, 4);
    check_output("post-reset no match", n_match + n_learned, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
